// File: rtl/muladd_pkg.sv
// Shared defaults and beat formats for the multiply-add streaming responder.
// The structs describe the default-width operand and product beats.
package muladd_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH-1:0] c;
  } operand_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] p;
    logic [DEF_WIDTH-1:0] c;
  } stage1_t;

endpackage

// File: rtl/muladd_stage.sv
// Generic valid/data pipeline register that collapses bubbles: it loads
// whenever it is empty or its current content is leaving this cycle.
module muladd_stage
  import muladd_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         down_ready,
  output logic         up_ready,
  output logic         valid,
  output logic [W-1:0] data
);

  assign up_ready = !valid || down_ready;

  // Data only moves with a valid beat so the last result stays visible when empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (up_ready) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/muladd_stream.sv
// Streaming y = a*b + c (mod 2^WIDTH) with a 3-stage bubble-collapsing pipeline,
// full valid/ready backpressure and a completed-result counter.
module muladd_stream
  import muladd_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y,
  output logic [CNT_WIDTH-1:0] count
);

  // Same layout as the package beats, but sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
  } prod_t;

  op_t              s0_in;
  op_t              s0_q;
  prod_t            s1_in;
  prod_t            s1_q;
  logic [WIDTH-1:0] s2_in;
  logic [WIDTH-1:0] s2_q;
  logic             v0;
  logic             v1;
  logic             v2;
  logic             ready0;
  logic             ready1;
  logic             ready2;

  always_comb begin
    s0_in   = '0;
    s0_in.a = a;
    s0_in.b = b;
    s0_in.c = c;
  end

  // Only the low WIDTH bits of the product survive; this is the DSP multiply.
  always_comb begin
    s1_in   = '0;
    s1_in.p = s0_q.a * s0_q.b;
    s1_in.c = s0_q.c;
  end

  assign s2_in = s1_q.p + s1_q.c;

  muladd_stage #(.W($bits(op_t))) u_stage0 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (s0_in),
    .down_ready (ready1),
    .up_ready   (ready0),
    .valid      (v0),
    .data       (s0_q)
  );

  muladd_stage #(.W($bits(prod_t))) u_stage1 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (v0),
    .in_data    (s1_in),
    .down_ready (ready2),
    .up_ready   (ready1),
    .valid      (v1),
    .data       (s1_q)
  );

  muladd_stage #(.W(WIDTH)) u_stage2 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (v1),
    .in_data    (s2_in),
    .down_ready (out_ready),
    .up_ready   (ready2),
    .valid      (v2),
    .data       (s2_q)
  );

  // The ready chain is purely combinational back to out_ready; no skid buffer.
  assign in_ready  = ready0 && !reset;
  assign out_valid = v2;
  assign y         = s2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (v2 && out_ready) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule
